// File: rtl/link_tx_scheduler_if.sv
// rtl/link_tx_scheduler_if.sv - requester-side flit handshake bundle for link_tx_scheduler
//  Signals:
//   req        requester i has a flit valid
//   req_data   flit of requester i at [i*DW +: DW], bit DW-1 = tail flag
//   req_ready  flit of requester i accepted this cycle
//  Modports: master = requesters, slave = scheduler.
`ifndef CDATASIZE
`define CDATASIZE 8
`endif

interface link_tx_scheduler_if #(
    parameter int NREQ = 2,
    parameter int DW   = `CDATASIZE
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req, output req_data, input req_ready);
    modport slave  (input req, input req_data, output req_ready);
endinterface

// File: rtl/link_tx_scheduler.sv
// rtl/link_tx_scheduler.sv - round-robin, packet-locked TX sequencer for the strobe/state link
//  Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rq              requester bundle (slave side): req, req_data, req_ready
//   Feedback_p2r    receiver back-pressure, asynchronous to clk
//   CData_r2p       flit to receiver (registered, holds between transfers)
//   Strobe_r2p      toggles once per flit sent
//   State_r2p       high while a packet is in progress
//   grant_id        currently granted requester
//   busy            FSM not idle
//   sent_cnt        flits sent since reset, wrapping
`ifndef CDATASIZE
`define CDATASIZE 8
`endif

module link_tx_scheduler #(
    parameter int NREQ = 2,
    parameter int DW   = `CDATASIZE,
    parameter int GAP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    link_tx_scheduler_if.slave  rq,
    input  logic                Feedback_p2r,
    output logic [DW-1:0]       CData_r2p,
    output logic                Strobe_r2p,
    output logic                State_r2p,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic [15:0]         sent_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, GAPW} state_t;

    state_t        state, state_n;
    logic [1:0]    rr_ptr;
    logic [1:0]    pick;
    logic          pick_found;
    logic [2:0]    idx;
    logic [3:0]    gap_cnt;
    logic          last_tail;
    logic          fb_meta, fb_s;
    logic          sel_req;
    logic [DW-1:0] sel_data;
    logic          sel_tail;
    logic          xfer;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + 3'(k);
            if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!pick_found && idx == 3'(j) && rq.req[j]) begin
                    pick       = 2'(j);
                    pick_found = 1'b1;
                end
            end
        end
    end

    // Mux of the granted requester's valid and flit.
    always_comb begin
        sel_req  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_req  = rq.req[i];
                sel_data = rq.req_data[i*DW +: DW];
            end
        end
    end

    assign sel_tail = sel_data[DW-1];
    assign busy     = (state != IDLE);

    always_comb begin
        state_n      = state;
        xfer         = 1'b0;
        rq.req_ready = '0;
        case (state)
            IDLE: begin
                if (pick_found) state_n = SEND;
            end
            SEND: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_id == 2'(i)) rq.req_ready[i] = rq.req[i] & ~fb_s;
                end
                xfer = sel_req & ~fb_s;
                if (xfer) begin
                    if (GAP > 1)       state_n = GAPW;
                    else if (sel_tail) state_n = IDLE;
                end
            end
            GAPW: begin
                if (gap_cnt == 4'd1) state_n = last_tail ? IDLE : SEND;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gap_cnt    <= '0;
            last_tail  <= 1'b0;
            fb_meta    <= 1'b0;
            fb_s       <= 1'b0;
            grant_id   <= '0;
            CData_r2p  <= '0;
            Strobe_r2p <= 1'b0;
            State_r2p  <= 1'b0;
            sent_cnt   <= '0;
        end else begin
            fb_meta <= Feedback_p2r;
            fb_s    <= fb_meta;
            state   <= state_n;
            if (state == IDLE && pick_found) grant_id <= pick;
            if (xfer) begin
                CData_r2p  <= sel_data;
                Strobe_r2p <= ~Strobe_r2p;
                State_r2p  <= 1'b1;
                sent_cnt   <= sent_cnt + 16'd1;
                last_tail  <= sel_tail;
                gap_cnt    <= 4'(GAP - 1);
                if (sel_tail) rr_ptr <= (grant_id == 2'(NREQ - 1)) ? 2'd0 : grant_id + 2'd1;
            end else begin
                // With GAP==1 a tail goes straight to IDLE, so State_r2p drops in the idle cycle.
                if (state_n == IDLE || state == IDLE) State_r2p <= 1'b0;
                if (state == GAPW) gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb/tb_link_tx_scheduler.sv - directed self-checking bench for link_tx_scheduler
module tb_link_tx_scheduler;
    localparam int NREQ = 2;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          fb0 = 1'b0, fb1 = 1'b0;
    logic [DW-1:0] cdata0, cdata1;
    logic          strobe0, strobe1, state0, state1, busy0, busy1;
    logic [1:0]    gid0, gid1;
    logic [15:0]   cnt0, cnt1;

    link_tx_scheduler_if #(.NREQ(NREQ), .DW(DW)) rq0 ();
    link_tx_scheduler_if #(.NREQ(NREQ), .DW(DW)) rq1 ();

    link_tx_scheduler #(.NREQ(NREQ), .DW(DW), .GAP(2)) dut (
        .clk(clk), .rst(rst), .rq(rq0), .Feedback_p2r(fb0),
        .CData_r2p(cdata0), .Strobe_r2p(strobe0), .State_r2p(state0),
        .grant_id(gid0), .busy(busy0), .sent_cnt(cnt0)
    );

    link_tx_scheduler #(.NREQ(NREQ), .DW(DW), .GAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .rq(rq1), .Feedback_p2r(fb1),
        .CData_r2p(cdata1), .Strobe_r2p(strobe1), .State_r2p(state1),
        .grant_id(gid1), .busy(busy1), .sent_cnt(cnt1)
    );

    int cmp_n = 0;
    int err_n = 0;
    int cyc   = 0;

    logic [7:0] fq [2][$];
    bit         en [2];
    int         tog_cyc[$];
    logic [7:0] tog_data[$];
    logic [1:0] tog_gid[$];
    logic       prev_strobe = 1'b0, prev_state = 1'b0;
    int         rise_cyc, fall_cyc;
    int         rdy_pulses [2];
    logic [1:0] last_rdy;

    function automatic void drive();
        for (int i = 0; i < NREQ; i++) begin
            rq0.req[i] = en[i] && (fq[i].size() > 0);
            rq0.req_data[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
        end
    endfunction

    function automatic void clear_logs();
        tog_cyc.delete();
        tog_data.delete();
        tog_gid.delete();
        rdy_pulses[0] = 0;
        rdy_pulses[1] = 0;
        rise_cyc = -1;
        fall_cyc = -1;
    endfunction

    // One clock: sample mid-cycle, then advance the requester model after the edge.
    task automatic step();
        logic [1:0] acc;
        @(negedge clk);
        last_rdy = rq0.req_ready;
        acc      = rq0.req & rq0.req_ready;
        for (int i = 0; i < NREQ; i++) if (last_rdy[i]) rdy_pulses[i]++;
        if (!rst && strobe0 !== prev_strobe) begin
            tog_cyc.push_back(cyc);
            tog_data.push_back(cdata0);
            tog_gid.push_back(gid0);
        end
        prev_strobe = strobe0;
        if (!rst && state0 && !prev_state) rise_cyc = cyc;
        if (!rst && !state0 && prev_state) fall_cyc = cyc;
        prev_state = state0;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (acc[i]) void'(fq[i].pop_front());
        drive();
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            step();
            if (fq[0].size() == 0 && fq[1].size() == 0 && !busy0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        cmp_n++; if (cdata0 !== 8'h00) begin err_n++; $display("FAIL reset_cdata: got %0h, expected 0", cdata0); end
        cmp_n++; if (strobe0 !== 1'b0) begin err_n++; $display("FAIL reset_strobe: got %0b, expected 0", strobe0); end
        cmp_n++; if (state0 !== 1'b0) begin err_n++; $display("FAIL reset_state: got %0b, expected 0", state0); end
        cmp_n++; if (gid0 !== 2'd0) begin err_n++; $display("FAIL reset_grant: got %0d, expected 0", gid0); end
        cmp_n++; if (busy0 !== 1'b0) begin err_n++; $display("FAIL reset_busy: got %0b, expected 0", busy0); end
        cmp_n++; if (cnt0 !== 16'h0) begin err_n++; $display("FAIL reset_cnt: got %0h, expected 0", cnt0); end
        cmp_n++; if (rq0.req_ready !== 2'b00) begin err_n++; $display("FAIL reset_ready: got %0b, expected 0", rq0.req_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_pkt();
        int n0;
        bit ok;
        logic [7:0] ed[$];
        ed = '{8'h11, 8'h22, 8'h93};
        clear_logs();
        fq[0] = ed;
        n0 = cyc;
        drive();
        wait_idle(60, ok);
        cmp_n++; if (!ok) begin err_n++; $display("FAIL single_timeout: got busy, expected idle"); end
        cmp_n++; if (tog_cyc.size() != 3) begin err_n++; $display("FAIL single_toggles: got %0d, expected 3", tog_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            cmp_n++;
            if (i >= tog_data.size() || tog_data[i] !== ed[i]) begin
                err_n++; $display("FAIL single_data%0d: got %0h, expected %0h", i, (i < tog_data.size()) ? tog_data[i] : 8'hxx, ed[i]);
            end
        end
        if (tog_cyc.size() == 3) begin
            cmp_n++; if (tog_cyc[0] != n0 + 2) begin err_n++; $display("FAIL single_first_toggle: got %0d, expected %0d", tog_cyc[0], n0 + 2); end
            cmp_n++; if (tog_cyc[1] - tog_cyc[0] != 2) begin err_n++; $display("FAIL single_spacing1: got %0d, expected 2", tog_cyc[1] - tog_cyc[0]); end
            cmp_n++; if (tog_cyc[2] - tog_cyc[1] != 2) begin err_n++; $display("FAIL single_spacing2: got %0d, expected 2", tog_cyc[2] - tog_cyc[1]); end
            cmp_n++; if (rise_cyc != tog_cyc[0]) begin err_n++; $display("FAIL single_state_rise: got %0d, expected %0d", rise_cyc, tog_cyc[0]); end
            cmp_n++; if (fall_cyc != tog_cyc[0] + 5) begin err_n++; $display("FAIL single_state_fall: got %0d, expected %0d", fall_cyc, tog_cyc[0] + 5); end
        end
        cmp_n++; if (rdy_pulses[0] != 3) begin err_n++; $display("FAIL single_ready_pulses: got %0d, expected 3", rdy_pulses[0]); end
        cmp_n++; if (cnt0 !== 16'd3) begin err_n++; $display("FAIL single_cnt: got %0d, expected 3", cnt0); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] ed[$];
        logic [1:0] eg[$];
        rst = 1'b1;
        step();
        clear_logs();
        fq[0] = '{8'h01, 8'h82};
        fq[1] = '{8'h05, 8'h86};
        drive();
        rst = 1'b0;
        wait_idle(80, ok);
        cmp_n++; if (!ok) begin err_n++; $display("FAIL rr_timeout1: got busy, expected idle"); end
        fq[0] = '{8'h03, 8'h84};
        fq[1] = '{8'h07, 8'h88};
        drive();
        wait_idle(80, ok);
        cmp_n++; if (!ok) begin err_n++; $display("FAIL rr_timeout2: got busy, expected idle"); end
        fq[0] = '{8'h90};
        drive();
        wait_idle(40, ok);
        fq[0] = '{8'h91};
        fq[1] = '{8'h92};
        drive();
        wait_idle(60, ok);
        cmp_n++; if (!ok) begin err_n++; $display("FAIL rr_timeout3: got busy, expected idle"); end
        ed = '{8'h01, 8'h82, 8'h05, 8'h86, 8'h03, 8'h84, 8'h07, 8'h88, 8'h90, 8'h92, 8'h91};
        eg = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0};
        cmp_n++; if (tog_data.size() != ed.size()) begin err_n++; $display("FAIL rr_count: got %0d, expected %0d", tog_data.size(), ed.size()); end
        for (int i = 0; i < ed.size(); i++) begin
            cmp_n++;
            if (i >= tog_data.size() || tog_data[i] !== ed[i] || tog_gid[i] !== eg[i]) begin
                err_n++;
                $display("FAIL rr_flit%0d: got %0h/g%0d, expected %0h/g%0d", i,
                         (i < tog_data.size()) ? tog_data[i] : 8'hxx, (i < tog_gid.size()) ? tog_gid[i] : 2'bxx, ed[i], eg[i]);
            end
        end
        cmp_n++; if (cnt0 !== 16'd11) begin err_n++; $display("FAIL rr_cnt: got %0d, expected 11", cnt0); end
    endtask

    task automatic test_feedback();
        int f, s, base;
        bit done;
        logic [7:0] ed[$];
        ed = '{8'h21, 8'h22, 8'h23, 8'h24, 8'hA5};
        clear_logs();
        base = int'(cnt0);
        fq[0] = ed;
        drive();
        for (int n = 0; n < 40 && tog_cyc.size() < 2; n++) step();
        f = cyc;
        fb0 = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (cyc == f + 3) fb0 = 1'b0;
            step();
            s = cyc - 1;
            if (s >= f + 2 && s <= f + 4) begin
                cmp_n++; if (last_rdy !== 2'b00) begin err_n++; $display("FAIL fb_ready_stall_c%0d: got %0b, expected 00", s - f, last_rdy); end
            end
            if (s == f + 5) begin
                cmp_n++; if (last_rdy !== 2'b01) begin err_n++; $display("FAIL fb_ready_resume: got %0b, expected 01", last_rdy); end
            end
            if (s > f + 6 && fq[0].size() == 0 && !busy0) begin
                done = 1'b1;
                break;
            end
        end
        fb0 = 1'b0;
        step();
        cmp_n++; if (!done) begin err_n++; $display("FAIL fb_timeout: got busy, expected idle"); end
        cmp_n++; if (tog_data.size() != 5) begin err_n++; $display("FAIL fb_count: got %0d, expected 5", tog_data.size()); end
        for (int i = 0; i < 5; i++) begin
            cmp_n++;
            if (i >= tog_data.size() || tog_data[i] !== ed[i]) begin
                err_n++; $display("FAIL fb_data%0d: got %0h, expected %0h", i, (i < tog_data.size()) ? tog_data[i] : 8'hxx, ed[i]);
            end
        end
        if (tog_cyc.size() == 5) begin
            cmp_n++; if (tog_cyc[2] != f + 1) begin err_n++; $display("FAIL fb_toggle_before: got %0d, expected %0d", tog_cyc[2] - f, 1); end
            cmp_n++; if (tog_cyc[3] != f + 6) begin err_n++; $display("FAIL fb_toggle_after: got %0d, expected %0d", tog_cyc[3] - f, 6); end
        end
        cmp_n++; if (int'(cnt0) != base + 5) begin err_n++; $display("FAIL fb_cnt: got %0d, expected %0d", cnt0, base + 5); end
    endtask

    task automatic test_req_drop();
        int d;
        bit ok;
        logic [7:0] ed[$];
        ed = '{8'h31, 8'h32, 8'h33, 8'h34, 8'hB5, 8'h41, 8'hC2};
        clear_logs();
        fq[0] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'hB5};
        drive();
        for (int n = 0; n < 40 && tog_cyc.size() < 1; n++) step();
        fq[1] = '{8'h41, 8'hC2};
        drive();
        for (int n = 0; n < 40 && tog_cyc.size() < 2; n++) step();
        d = cyc;
        en[0] = 1'b0;
        drive();
        for (int n = 0; n < 4; n++) begin
            step();
            cmp_n++; if (state0 !== 1'b1) begin err_n++; $display("FAIL drop_state_c%0d: got %0b, expected 1", n, state0); end
            cmp_n++; if (gid0 !== 2'd0) begin err_n++; $display("FAIL drop_grant_c%0d: got %0d, expected 0", n, gid0); end
            cmp_n++; if (last_rdy !== 2'b00) begin err_n++; $display("FAIL drop_ready_c%0d: got %0b, expected 00", n, last_rdy); end
        end
        en[0] = 1'b1;
        drive();
        wait_idle(80, ok);
        cmp_n++; if (!ok) begin err_n++; $display("FAIL drop_timeout: got busy, expected idle"); end
        if (tog_cyc.size() > 2) begin
            cmp_n++; if (tog_cyc[2] != d + 5) begin err_n++; $display("FAIL drop_resume: got %0d, expected %0d", tog_cyc[2] - d, 5); end
        end
        cmp_n++; if (tog_data.size() != ed.size()) begin err_n++; $display("FAIL drop_count: got %0d, expected %0d", tog_data.size(), ed.size()); end
        for (int i = 0; i < ed.size(); i++) begin
            cmp_n++;
            if (i >= tog_data.size() || tog_data[i] !== ed[i] || tog_gid[i] !== ((i < 5) ? 2'd0 : 2'd1)) begin
                err_n++; $display("FAIL drop_flit%0d: got %0h, expected %0h", i, (i < tog_data.size()) ? tog_data[i] : 8'hxx, ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_pkt();
        bit ok;
        clear_logs();
        fq[0] = '{8'h51, 8'h52, 8'h53, 8'hD4};
        drive();
        for (int n = 0; n < 40 && tog_cyc.size() < 1; n++) step();
        #2;
        rst = 1'b1;
        #1;
        cmp_n++; if (cdata0 !== 8'h00) begin err_n++; $display("FAIL arst_cdata: got %0h, expected 0", cdata0); end
        cmp_n++; if (strobe0 !== 1'b0) begin err_n++; $display("FAIL arst_strobe: got %0b, expected 0", strobe0); end
        cmp_n++; if (state0 !== 1'b0) begin err_n++; $display("FAIL arst_state: got %0b, expected 0", state0); end
        cmp_n++; if (gid0 !== 2'd0) begin err_n++; $display("FAIL arst_grant: got %0d, expected 0", gid0); end
        cmp_n++; if (busy0 !== 1'b0) begin err_n++; $display("FAIL arst_busy: got %0b, expected 0", busy0); end
        cmp_n++; if (cnt0 !== 16'h0) begin err_n++; $display("FAIL arst_cnt: got %0h, expected 0", cnt0); end
        fq[0].delete();
        fq[1] = '{8'h61, 8'hE2};
        drive();
        step();
        rst = 1'b0;
        clear_logs();
        wait_idle(60, ok);
        cmp_n++; if (!ok) begin err_n++; $display("FAIL arst_timeout: got busy, expected idle"); end
        cmp_n++; if (tog_data.size() != 2) begin err_n++; $display("FAIL arst_count: got %0d, expected 2", tog_data.size()); end
        if (tog_data.size() == 2) begin
            cmp_n++; if (tog_data[0] !== 8'h61 || tog_gid[0] !== 2'd1) begin err_n++; $display("FAIL arst_flit0: got %0h/g%0d, expected 61/g1", tog_data[0], tog_gid[0]); end
            cmp_n++; if (tog_data[1] !== 8'hE2 || tog_gid[1] !== 2'd1) begin err_n++; $display("FAIL arst_flit1: got %0h/g%0d, expected e2/g1", tog_data[1], tog_gid[1]); end
        end
        cmp_n++; if (cnt0 !== 16'd2) begin err_n++; $display("FAIL arst_cnt_after: got %0d, expected 2", cnt0); end
    endtask

    task automatic test_wrap();
        int k;
        bit hit;
        logic sp;
        rq1.req      = 2'b01;
        rq1.req_data = 16'h0055;
        hit = 1'b0;
        k   = 0;
        sp  = strobe1;
        while (k < 70000) begin
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                cmp_n++; if (strobe1 === sp) begin err_n++; $display("FAIL wrap_rate_c%0d: got no toggle, expected toggle", k); end
            end
            sp = strobe1;
            if (cnt1 === 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
            k++;
        end
        cmp_n++; if (!hit || k != 65536) begin err_n++; $display("FAIL wrap_reach: got %0d cycles, expected 65536", k); end
        rq1.req_data = 16'h00D5;
        @(negedge clk);
        cmp_n++; if (cnt1 !== 16'h0000) begin err_n++; $display("FAIL wrap_cnt: got %0h, expected 0", cnt1); end
        cmp_n++; if (cdata1 !== 8'hD5) begin err_n++; $display("FAIL wrap_data: got %0h, expected d5", cdata1); end
        cmp_n++; if (busy1 !== 1'b0) begin err_n++; $display("FAIL wrap_idle: got %0b, expected 0", busy1); end
        rq1.req = 2'b00;
    endtask

    initial begin
        en[0] = 1'b1;
        en[1] = 1'b1;
        rq1.req      = 2'b00;
        rq1.req_data = '0;
        clear_logs();
        drive();
        test_reset();
        test_single_pkt();
        test_round_robin();
        test_feedback();
        test_req_drop();
        test_reset_mid_pkt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
